// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding APB master that turns a valid/ready command
//            into an APB SETUP/ACCESS transfer and a one-cycle response pulse.
//            Define APB_MASTER_TIMEOUT_EN to compile in the ACCESS wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic                    pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]        wait_cnt_q,  wait_cnt_d;
    logic                    rsp_err_q,   rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // A late PREADY on the limit cycle wins over the timeout.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Handshake and APB strobes come straight from the state register.
    assign cmd_ready = (state_q == ST_IDLE);
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Directed self-checking bench for apb_master (default build, plus
//            the timeout cases when APB_MASTER_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_total = 0;
    int n_bad   = 0;

    // Results of the most recent xfer() call
    int   last_acc;
    int   last_steps;
    logic last_stable;
    logic last_setup_ok;
    logic last_rv_seen;
    logic last_hung;

    apb_master #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one request from IDLE; PREADY stays low for nwait ACCESS cycles.
    // Returns in the cycle after PSEL drops (the expected rsp_valid cycle).
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int nwait);
        int budget;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        PRDATA    = rd;
        PREADY    = 1'b0;
        step();
        cmd_valid     = 1'b0;
        last_acc      = 0;
        last_stable   = 1'b1;
        last_setup_ok = (PSEL === 1'b1) && (PENABLE === 1'b0);
        last_rv_seen  = 1'b0;
        budget        = 0;
        while (PSEL === 1'b1 && budget < 100) begin
            if (PADDR !== a || PWRITE !== wr || PWDATA !== wd) last_stable = 1'b0;
            if (rsp_valid === 1'b1) last_rv_seen = 1'b1;
            if (PENABLE === 1'b1) last_acc++;
            PREADY = (last_acc > nwait);
            step();
            budget++;
        end
        last_steps = budget;
        last_hung  = (budget >= 100);
        PREADY     = 1'b0;
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        step();
        step();
        PRESETn = 1'b1;

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel",      PSEL,      0);
        chk("rst_penable",   PENABLE,   0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr",     PADDR,     0);
        chk("rst_pwdata",    PWDATA,    0);
        chk("rst_rdata",     rsp_rdata, 0);
        chk("rst_err",       rsp_err,   0);

        // Zero-wait write
        xfer(1'b1, 4'h2, 32'hDEADBEEF, 32'h0, 0);
        chk("wr_setup",     last_setup_ok,  1);
        chk("wr_stable",    last_stable,    1);
        chk("wr_acc",       last_acc,       1);
        chk("wr_latency",   last_steps + 1, 3);
        chk("wr_rv_early",  last_rv_seen,   0);
        chk("wr_rsp_valid", rsp_valid,      1);
        chk("wr_rsp_err",   rsp_err,        0);
        chk("wr_rdata",     rsp_rdata,      0);
        chk("wr_ready",     cmd_ready,      1);
        step();
        chk("wr_rv_pulse",  rsp_valid,      0);

        // Read, then a write clears rsp_rdata
        xfer(1'b0, 4'h1, 32'h0, 32'h12345678, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata",     rsp_rdata, 32'h12345678);
        PRDATA = 32'hFFFF0000;
        step();
        chk("rd_hold",      rsp_rdata, 32'h12345678);
        chk("rd_rv_pulse",  rsp_valid, 0);
        xfer(1'b1, 4'h3, 32'h0BADF00D, 32'h77777777, 0);
        chk("wr2_rdata",    rsp_rdata, 0);
        step();

        // Four wait states
        xfer(1'b1, 4'h7, 32'hA5A5A5A5, 32'h0, 4);
        chk("ws_acc",       last_acc,     5);
        chk("ws_stable",    last_stable,  1);
        chk("ws_rv_early",  last_rv_seen, 0);
        chk("ws_hung",      last_hung,    0);
        chk("ws_rsp_valid", rsp_valid,    1);
        step();
        chk("ws_rv_pulse",  rsp_valid,    0);

        // Back-to-back with cmd_valid held; second request offered while busy
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h11112222;
        PREADY = 1'b1;
        step();
        cmd_write = 1'b0; cmd_addr = 4'h9; cmd_wdata = 32'h0; PRDATA = 32'hCAFEF00D;
        chk("b2b_busy_ready", cmd_ready, 0);
        step();
        chk("b2b_ignored",    PADDR,     4'h4);
        step();
        chk("b2b_rv1",        rsp_valid, 1);
        chk("b2b_gap_psel",   PSEL,      0);
        chk("b2b_ready",      cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("b2b_setup2",     PSEL,      1);
        chk("b2b_addr2",      PADDR,     4'h9);
        chk("b2b_write2",     PWRITE,    0);
        step();
        chk("b2b_access2",    PENABLE,   1);
        step();
        chk("b2b_rv2",        rsp_valid, 1);
        chk("b2b_rdata2",     rsp_rdata, 32'hCAFEF00D);
        PREADY = 1'b0;

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h000055AA;
        step();
        cmd_valid = 1'b0;
        step();
        chk("mr_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        step();
        PRESETn = 1'b1;
        chk("mr_psel",      PSEL,      0);
        chk("mr_penable",   PENABLE,   0);
        chk("mr_pwrite",    PWRITE,    0);
        chk("mr_paddr",     PADDR,     0);
        chk("mr_pwdata",    PWDATA,    0);
        chk("mr_rdata",     rsp_rdata, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_ready",     cmd_ready, 1);
        step();
        chk("mr_no_rv",     rsp_valid, 0);
        xfer(1'b0, 4'h6, 32'h0, 32'hA5A50F0F, 1);
        chk("mr_post_acc",   last_acc,  2);
        chk("mr_post_rv",    rsp_valid, 1);
        chk("mr_post_rdata", rsp_rdata, 32'hA5A50F0F);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: 16 counted wait cycles, exit on the 17th ACCESS cycle
        xfer(1'b0, 4'hA, 32'h0, 32'h99999999, 1000);
        chk("to_acc",       last_acc,  17);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err",   rsp_err,   1);
        chk("to_rdata",     rsp_rdata, 0);
        step();
        chk("to_rv_pulse",  rsp_valid, 0);
        // PREADY arrives on the limit cycle: normal completion
        xfer(1'b0, 4'hB, 32'h0, 32'h13579BDF, 16);
        chk("lim_acc",      last_acc,  17);
        chk("lim_rsp_err",  rsp_err,   0);
        chk("lim_rdata",    rsp_rdata, 32'h13579BDF);
        step();
`else
        // Without the timeout the master waits as long as the slave stalls
        xfer(1'b0, 4'hA, 32'h0, 32'h24681357, 30);
        chk("long_acc",     last_acc,  31);
        chk("long_hung",    last_hung, 0);
        chk("long_rv",      rsp_valid, 1);
        chk("long_err",     rsp_err,   0);
        chk("long_rdata",   rsp_rdata, 32'h24681357);
        step();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001: Parameter ADDR_WIDTH, default 4, APB address width.
REQ-002: Parameter DATA_WIDTH, default 32, APB data width.
REQ-003: Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles, used only when the timeout feature is compiled in.
REQ-004: PCLK  input  1  single clock; all state updates on its rising edge.
REQ-005: PRESETn  input  1  reset; synchronous and active-low.
REQ-006: cmd_valid  input  1  request offered by the local requester.
REQ-007: cmd_ready  output  1  master can accept a request this cycle.
REQ-008: cmd_write  input  1  1 = write, 0 = read.
REQ-009: cmd_addr  input  ADDR_WIDTH  request address.
REQ-010: cmd_wdata  input  DATA_WIDTH  request write data.
REQ-011: rsp_valid  output  1  one-cycle completion pulse.
REQ-012: rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid for reads.
REQ-013: rsp_err  output  1  completion terminated by timeout; valid with rsp_valid.
REQ-014: PSEL, PENABLE, PWRITE  output  1 each  APB control signals to the slave.
REQ-015: PADDR  output  ADDR_WIDTH  APB address.
REQ-016: PWDATA  output  DATA_WIDTH  APB write data.
REQ-017: PRDATA  input  DATA_WIDTH  APB read data from the slave.
REQ-018: PREADY  input  1  APB transfer ready from the slave.

Function
REQ-019: The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-020: cmd_ready SHALL be 1 only in IDLE.
REQ-021: A request is accepted on the edge where cmd_valid and cmd_ready are both 1.
  - cmd_write, cmd_addr and cmd_wdata are registered into PWRITE, PADDR and PWDATA on that edge.
  - The FSM moves to SETUP on that edge.
REQ-022: PWRITE, PADDR and PWDATA SHALL hold stable from acceptance until the next acceptance.
REQ-023: SETUP SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then move unconditionally to ACCESS.
REQ-024: ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL remain in ACCESS while PREADY=0.
REQ-025: In IDLE, PSEL and PENABLE SHALL both be 0.
REQ-026: On an ACCESS cycle with PREADY=1, the FSM SHALL return to IDLE.
  - rsp_valid is 1 in the following cycle, and only that cycle.
  - rsp_err is 0.
REQ-027: rsp_rdata SHALL capture PRDATA on the completing edge for reads, SHALL load 0 for writes, and SHALL hold until the next completion.
REQ-028: Minimum latency from acceptance to rsp_valid SHALL be 3 cycles (zero-wait slave). A new request may be accepted in the same cycle rsp_valid is high.
REQ-029: Requests offered outside IDLE SHALL be ignored (cmd_ready=0); the requester holds them.
REQ-030: PSEL, PENABLE and cmd_ready SHALL be decoded from the state register only, with no combinational path from inputs.

Reset
REQ-031: While PRESETn=0 at a rising edge, the FSM SHALL go to IDLE and the following SHALL clear to 0: PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, and the wait counter.
REQ-032: Reset asserted during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid.
  - PSEL=0 from the cycle after the reset edge.
REQ-033: After reset, cmd_ready SHALL be 1 in the first cycle.

Configuration
REQ-034: Macro APB_MASTER_TIMEOUT_EN SHALL compile in the ACCESS wait-timeout feature.
REQ-035: With APB_MASTER_TIMEOUT_EN, the timeout SHALL behave as follows:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES with PREADY still 0, the FSM returns to IDLE, and the next cycle has rsp_valid=1, rsp_err=1 and rsp_rdata=0.
  - PREADY=1 in the same cycle as the limit is reached SHALL count as normal completion, with rsp_err=0.
REQ-036: Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-037: Zero-wait write: cmd write addr=0x2, data=0xDEADBEEF, PREADY=1 -> SETUP 1 cycle; ACCESS 1 cycle with PADDR=0x2 and PWDATA=0xDEADBEEF; rsp_valid 3 cycles after acceptance; rsp_err=0.
REQ-038: Read: slave returns PRDATA=0x12345678 at addr=0x1 with PREADY=1 -> rsp_rdata=0x12345678 alongside rsp_valid; a write completion then yields rsp_rdata=0.
REQ-039: Wait states: PREADY held 0 for 4 ACCESS cycles then 1 -> PSEL and PENABLE stay 1 for 5 cycles, one rsp_valid pulse, PADDR stable throughout.
REQ-040: Back-to-back: cmd_valid held high for two requests -> second accepted in the rsp_valid cycle of the first; no PSEL gap beyond one IDLE cycle.
REQ-041: Reset mid-ACCESS: PRESETn=0 for 1 cycle during ACCESS -> IDLE, all outputs 0, no rsp_valid; a subsequent request completes normally.
REQ-042: APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and PREADY tied 0 -> exit after 16 wait cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0.
